// File: rtl/grid_led_ctrl.sv
// LED-grid driver for the card-matching game: found map, selection, blinking cursor and timed mismatch reveal.
// Optional GRID_LED_WIN_ANIM_EN: the whole grid blinks in WIN instead of staying lit.
module grid_led_ctrl #(
    parameter int ROWS        = 6,
    parameter int COLS        = 6,
    parameter int BLINK_HALF  = 12_500_000,
    parameter int SHOW_CYCLES = 25_000_000,
    localparam int N  = ROWS * COLS,
    localparam int AW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          new_game,
    input  logic [AW-1:0] cursor,
    input  logic          sel_valid,
    input  logic [AW-1:0] sel_addr,
    input  logic          pair_valid,
    input  logic [AW-1:0] pair_a,
    input  logic [AW-1:0] pair_b,
    input  logic          pair_match,
    output logic [N-1:0]  leds,
    output logic [CW-1:0] found_count,
    output logic          all_found,
    output logic          busy
);
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam int BM = BLINK_HALF - 1;
    localparam int SM = SHOW_CYCLES - 1;
    localparam logic [BW-1:0] BMAX = BM[BW-1:0];
    localparam logic [SW-1:0] SMAX = SM[SW-1:0];
    localparam logic [AW:0]   NV   = N[AW:0];
    localparam logic [CW-1:0] NCNT = N[CW-1:0];

    if (N % 2 != 0) begin : g_grid_check
        $error("grid_led_ctrl: ROWS*COLS must be even");
    end

    typedef enum logic [1:0] {PLAY, SHOW, WIN} state_t;

    state_t        state;
    logic [N-1:0]  found;
    logic          sel_active;
    logic [AW-1:0] sel_reg, show_a, show_b;
    logic [BW-1:0] bcnt;
    logic          phase;
    logic [SW-1:0] scnt;
    logic [CW-1:0] cnt;

    logic [N-1:0]  a_oh, b_oh, sel_oh, cur_oh, sa_oh, sb_oh, led_play, led_win;
    logic          a_ok, b_ok, sel_ok, pair_ok;
    logic [CW-1:0] cnt_next;

    always_comb begin
        a_oh   = '0;
        b_oh   = '0;
        sel_oh = '0;
        cur_oh = '0;
        sa_oh  = '0;
        sb_oh  = '0;
        for (int i = 0; i < N; i++) begin
            a_oh[i]   = (pair_a == AW'(i));
            b_oh[i]   = (pair_b == AW'(i));
            sel_oh[i] = (sel_reg == AW'(i));
            cur_oh[i] = (cursor == AW'(i));
            sa_oh[i]  = (show_a == AW'(i));
            sb_oh[i]  = (show_b == AW'(i));
        end
    end

    // Addresses at or beyond N decode to nothing and are rejected as strobes.
    assign a_ok     = ({1'b0, pair_a} < NV);
    assign b_ok     = ({1'b0, pair_b} < NV);
    assign sel_ok   = ({1'b0, sel_addr} < NV);
    assign pair_ok  = (pair_a != pair_b) && a_ok && b_ok && ((found & (a_oh | b_oh)) == '0);
    assign cnt_next = cnt + CW'(2);

    assign led_play = found
                    | (sel_oh & {N{sel_active}})
                    | ((sa_oh | sb_oh) & {N{state == SHOW}})
                    | (cur_oh & {N{phase}});

`ifdef GRID_LED_WIN_ANIM_EN
    assign led_win = {N{phase}};
`else
    assign led_win = '1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= PLAY;
            found       <= '0;
            sel_active  <= 1'b0;
            sel_reg     <= '0;
            show_a      <= '0;
            show_b      <= '0;
            bcnt        <= '0;
            phase       <= 1'b1;
            scnt        <= '0;
            cnt         <= '0;
            leds        <= '0;
            found_count <= '0;
            all_found   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (new_game) begin
                bcnt  <= '0;
                phase <= 1'b1;
            end else if (bcnt == BMAX) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt  <= bcnt + BW'(1);
            end

            // Output registers reflect the state held before this edge.
            if (new_game) begin
                leds        <= '0;
                found_count <= '0;
                all_found   <= 1'b0;
                busy        <= 1'b0;
            end else begin
                leds        <= (state == WIN) ? led_win : led_play;
                found_count <= cnt;
                all_found   <= (state == WIN);
                busy        <= (state == SHOW);
            end

            if (new_game) begin
                state      <= PLAY;
                found      <= '0;
                sel_active <= 1'b0;
                cnt        <= '0;
                scnt       <= '0;
            end else begin
                case (state)
                    PLAY: begin
                        if (pair_valid) begin
                            if (pair_ok) begin
                                sel_active <= 1'b0;
                                if (pair_match) begin
                                    found <= found | a_oh | b_oh;
                                    cnt   <= cnt_next;
                                    if (cnt_next == NCNT) state <= WIN;
                                end else begin
                                    show_a <= pair_a;
                                    show_b <= pair_b;
                                    scnt   <= SMAX;
                                    state  <= SHOW;
                                end
                            end
                        end else if (sel_valid && sel_ok) begin
                            sel_reg    <= sel_addr;
                            sel_active <= 1'b1;
                        end
                    end
                    SHOW: begin
                        if (scnt == '0) state <= PLAY;
                        else            scnt  <= scnt - SW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_grid_led_ctrl.sv
// Bench for grid_led_ctrl: directed vector table, corner sequences and randomized traffic against a behavioural model.
module tb_grid_led_ctrl;
    localparam int ROWS = 6, COLS = 6, BH = 4, SC = 8, N = 36;
    localparam int ST_PLAY = 0, ST_SHOW = 1, ST_WIN = 2;

    logic        clock = 1'b0;
    logic        reset_n, new_game, sel_valid, pair_valid, pair_match;
    logic [5:0]  cursor, sel_addr, pair_a, pair_b;
    logic [35:0] leds;
    logic [5:0]  found_count;
    logic        all_found, busy;

    grid_led_ctrl #(.ROWS(ROWS), .COLS(COLS), .BLINK_HALF(BH), .SHOW_CYCLES(SC)) dut (
        .clock(clock), .reset_n(reset_n), .new_game(new_game), .cursor(cursor),
        .sel_valid(sel_valid), .sel_addr(sel_addr), .pair_valid(pair_valid),
        .pair_a(pair_a), .pair_b(pair_b), .pair_match(pair_match),
        .leds(leds), .found_count(found_count), .all_found(all_found), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;

    // behavioural model state
    bit mf[N];
    int mcnt, mst, msel, msa, msb, mleft, mk;
    bit mact;
    logic [63:0] e_leds;
    int e_cnt;
    bit e_af, e_busy;

    typedef struct {
        bit sv; int sa; bit pv; int pa; int pb; bit pm;
        logic [63:0] leds; int cnt; bit busy;
    } vec_t;
    vec_t tbl[11];

    function automatic logic [63:0] bm(input int a);
        return 64'd1 << a;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        foreach (mf[i]) mf[i] = 1'b0;
        mcnt = 0; mst = ST_PLAY; mact = 1'b0; msel = 0; msa = 0; msb = 0; mleft = 0; mk = 0;
    endtask

    task automatic model_edge();
        bit ph;
        logic [63:0] l;
        int a, b;
        if (new_game) begin
            e_leds = 0; e_cnt = 0; e_af = 0; e_busy = 0;
            model_clear();
            return;
        end
        ph = ((mk / BH) % 2) == 0;
        l = 0;
        if (mst == ST_WIN) begin
`ifdef GRID_LED_WIN_ANIM_EN
            l = ph ? (bm(N) - 64'd1) : 64'd0;
`else
            l = bm(N) - 64'd1;
`endif
        end else begin
            for (int i = 0; i < N; i++)
                if (mf[i] || (mact && msel == i) || (mst == ST_SHOW && (msa == i || msb == i)) ||
                    (int'(cursor) == i && ph))
                    l[i] = 1'b1;
        end
        e_leds = l; e_cnt = mcnt; e_af = (mst == ST_WIN); e_busy = (mst == ST_SHOW);
        mk++;
        a = int'(pair_a);
        b = int'(pair_b);
        if (mst == ST_PLAY) begin
            if (pair_valid) begin
                if (a != b && a < N && b < N && !mf[a] && !mf[b]) begin
                    mact = 1'b0;
                    if (pair_match) begin
                        mf[a] = 1'b1; mf[b] = 1'b1; mcnt += 2;
                        if (mcnt == N) mst = ST_WIN;
                    end else begin
                        msa = a; msb = b; mleft = SC; mst = ST_SHOW;
                    end
                end
            end else if (sel_valid && int'(sel_addr) < N) begin
                msel = int'(sel_addr); mact = 1'b1;
            end
        end else if (mst == ST_SHOW) begin
            mleft--;
            if (mleft == 0) mst = ST_PLAY;
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        if (reset_n) model_edge();
        #1;
        check("leds", 64'(leds), e_leds);
        check("found_count", 64'(found_count), 64'(e_cnt));
        check("all_found", 64'(all_found), 64'(e_af));
        check("busy", 64'(busy), 64'(e_busy));
    endtask

    task automatic clear_in();
        new_game = 1'b0; sel_valid = 1'b0; pair_valid = 1'b0; pair_match = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 3,  1'b0, 0, 0,  1'b0, bm(3), 0, 1'b0};
        tbl[1]  = '{1'b0, 0,  1'b1, 3, 20, 1'b1, bm(3) | bm(20), 2, 1'b0};
        tbl[2]  = '{1'b0, 0,  1'b1, 7, 9,  1'b0, bm(3) | bm(20) | bm(7) | bm(9), 2, 1'b1};
        tbl[3]  = '{1'b0, 0,  1'b1, 4, 5,  1'b1, bm(3) | bm(20) | bm(7) | bm(9), 2, 1'b1};
        tbl[4]  = '{1'b0, 0,  1'b0, 0, 0,  1'b0, bm(3) | bm(20) | bm(7) | bm(9), 2, 1'b1};
        tbl[5]  = '{1'b0, 0,  1'b0, 0, 0,  1'b0, bm(3) | bm(20) | bm(7) | bm(9), 2, 1'b1};
        tbl[6]  = '{1'b0, 0,  1'b0, 0, 0,  1'b0, bm(3) | bm(20), 2, 1'b0};
        tbl[7]  = '{1'b0, 0,  1'b1, 3, 20, 1'b1, bm(3) | bm(20), 2, 1'b0};
        tbl[8]  = '{1'b0, 0,  1'b1, 4, 4,  1'b1, bm(3) | bm(20), 2, 1'b0};
        tbl[9]  = '{1'b1, 40, 1'b0, 0, 0,  1'b0, bm(3) | bm(20), 2, 1'b0};
        tbl[10] = '{1'b1, 6,  1'b1, 4, 5,  1'b0, bm(3) | bm(20) | bm(4) | bm(5), 2, 1'b1};

        reset_n = 1'b0;
        clear_in();
        cursor = 6'd5; sel_addr = '0; pair_a = '0; pair_b = '0;
        model_clear();
        e_leds = 0; e_cnt = 0; e_af = 0; e_busy = 0;
        #12;
        check("reset_leds", 64'(leds), 64'd0);
        check("reset_count", 64'(found_count), 64'd0);
        check("reset_all_found", 64'(all_found), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;

        // cursor blink: lit for BH cycles, dark for BH cycles
        for (int j = 1; j <= 16; j++) begin
            cyc();
            check("blink", 64'(leds), (((j - 1) / BH) % 2 == 0) ? bm(5) : 64'd0);
        end

        cursor = 6'd63;
        new_game = 1'b1;
        cyc();
        clear_in();

        for (int r = 0; r < 11; r++) begin
            sel_valid = tbl[r].sv; sel_addr = 6'(tbl[r].sa);
            pair_valid = tbl[r].pv; pair_a = 6'(tbl[r].pa); pair_b = 6'(tbl[r].pb);
            pair_match = tbl[r].pm;
            cyc();
            clear_in();
            cyc();
            check($sformatf("tbl%0d_leds", r), 64'(leds), tbl[r].leds);
            check($sformatf("tbl%0d_count", r), 64'(found_count), 64'(tbl[r].cnt));
            check($sformatf("tbl%0d_busy", r), 64'(busy), 64'(tbl[r].busy));
        end

        // asynchronous reset while the mismatch is being shown
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_leds", 64'(leds), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_count", 64'(found_count), 64'd0);
        model_clear();
        e_leds = 0; e_cnt = 0; e_af = 0; e_busy = 0;
        #1 reset_n = 1'b1;
        pair_valid = 1'b1; pair_a = 6'd7; pair_b = 6'd9; pair_match = 1'b1;
        cyc();
        clear_in();
        cyc();
        check("post_rst_match_count", 64'(found_count), 64'd2);
        check("post_rst_busy", 64'(busy), 64'd0);

        // clear, then match every pair to reach WIN
        new_game = 1'b1;
        cyc();
        clear_in();
        for (int k = 0; k < N / 2; k++) begin
            pair_valid = 1'b1; pair_a = 6'(2 * k); pair_b = 6'(2 * k + 1); pair_match = 1'b1;
            cyc();
            clear_in();
        end
        cyc();
        check("win_count", 64'(found_count), 64'd36);
        check("win_all_found", 64'(all_found), 64'd1);
        for (int j = 0; j < 10; j++) begin
            pair_valid = 1'b1; pair_a = 6'd0; pair_b = 6'd1; pair_match = 1'b0;
            cyc();
`ifndef GRID_LED_WIN_ANIM_EN
            check("win_leds_steady", 64'(leds), bm(N) - 64'd1);
`endif
        end
        clear_in();
        new_game = 1'b1;
        cyc();
        clear_in();
        check("newgame_leds", 64'(leds), 64'd0);
        check("newgame_count", 64'(found_count), 64'd0);
        check("newgame_all_found", 64'(all_found), 64'd0);
        check("newgame_busy", 64'(busy), 64'd0);

        for (int j = 0; j < 3000; j++) begin
            new_game   = ($urandom_range(0, 299) == 0);
            sel_valid  = ($urandom_range(0, 2) == 0);
            sel_addr   = 6'($urandom_range(0, 39));
            pair_valid = ($urandom_range(0, 3) == 0);
            pair_a     = 6'($urandom_range(0, 39));
            pair_b     = 6'($urandom_range(0, 39));
            pair_match = ($urandom_range(0, 2) != 0);
            cursor     = 6'($urandom_range(0, 63));
            cyc();
        end
        clear_in();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/grid_led_ctrl.md
# grid_led_ctrl

Parametrised LED-grid driver for the card-matching game: owns a ROWS×COLS "found" map and drives one LED per card location from the found map, the currently selected card, a blinking cursor and a timed mismatch reveal. Sits between the game-control FSM (which reports selections and pair results) and the LED pins / VGA overlay. Generalises the fixed 6×6 grid driver to any grid size and adds reset, new-game clear, match counting, mismatch reveal timing and a win state.

## Interface
- ROWS, 6, grid rows
- COLS, 6, grid columns; N = ROWS*COLS must be even (elaboration-time check)
- BLINK_HALF, 12_500_000, cursor blink half-period in clock cycles (≥1)
- SHOW_CYCLES, 25_000_000, mismatch reveal duration in clock cycles (≥1)
- AW = $clog2(N), CW = $clog2(N+1) (derived localparams)

- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- new_game  in  1  synchronous clear of found map, selection, count, state
- cursor  in  AW  location currently hovered by the player
- sel_valid  in  1  one-cycle strobe: sel_addr is the first card of a pair
- sel_addr  in  AW  selected location
- pair_valid  in  1  one-cycle strobe: pair result available
- pair_a, pair_b  in  AW  the two locations of the pair
- pair_match  in  1  1 = cards match, 0 = mismatch
- leds  out  N  one bit per location, bit i = row i/COLS, column i%COLS
- found_count  out  CW  number of found locations
- all_found  out  1  level, high in WIN
- busy  out  1  high during mismatch reveal

## Operation
- States: PLAY, SHOW, WIN. Reset and new_game → PLAY.
- Registers: found[N], sel_active, sel_reg, show_a, show_b, blink counter, phase, show counter, found_count.
- sel_valid (PLAY only): sel_reg←sel_addr, sel_active←1. Ignored in SHOW/WIN or if sel_addr ≥ N.
- pair_valid (PLAY only), pair accepted iff pair_a≠pair_b, both < N, neither already found; otherwise ignored entirely (sel_active unchanged).
  - accepted, pair_match=1: found[a]←1, found[b]←1, found_count += 2, sel_active←0; if new count == N → WIN.
  - accepted, pair_match=0: show_a/b latched, sel_active←0, → SHOW, show counter loaded SHOW_CYCLES−1.
- SHOW: counter decrements; at 0 → PLAY. pair_valid/sel_valid ignored.
- WIN: until new_game; all inputs but new_game ignored.
- LED term for location i (PLAY/SHOW): found[i] | (sel_active & sel_reg==i) | (SHOW & (i==show_a | i==show_b)) | (cursor==i & phase). Cursor ≥ N lights nothing.
- Blink: counter counts 0..BLINK_HALF−1, phase toggles on wrap; free-running, cleared by reset and new_game (phase←1).
- Priority: reset_n > new_game > pair_valid > sel_valid. pair_valid and sel_valid in same cycle: pair processed, sel ignored.

## Timing
- Reset values: leds=0, found_count=0, all_found=0, busy=0, phase=1, found map all 0.
- leds, found_count, all_found, busy are registered: strobe at edge t visible after edge t+1 (1-cycle latency).
- busy high for exactly SHOW_CYCLES cycles after accepting a mismatch.
- reset_n assertion mid-SHOW or mid-WIN clears immediately (asynchronous); new_game clears on next edge.

## Configuration
- GRID_LED_WIN_ANIM_EN defined: in WIN, leds = all ones when phase=1, all zeros when phase=0 (whole grid blinks at BLINK_HALF).
- Not defined: in WIN, leds = all ones steady; blink counter still runs for the cursor in PLAY.

## Test plan
- ROWS=COLS=6, BLINK_HALF=4, SHOW_CYCLES=8; reset, cursor=5 -> leds[5] toggles every 4 cycles, all other bits 0, found_count=0.
- sel_valid addr 3, then pair_valid a=3 b=20 match=1 -> leds[3],leds[20] steady 1, found_count=2, sel cleared.
- pair_valid a=7 b=9 match=0 -> busy=1 and leds[7],leds[9]=1 for 8 cycles, then both 0; pair_valid during busy ignored.
- Repeat pair a=3 b=20 match=1, and pair a=4 b=4 -> no change, found_count stays 2.
- Match all 18 pairs -> found_count=36, all_found=1; with GRID_LED_WIN_ANIM_EN leds alternate 0xFFFFFFFFF/0 every 4 cycles, without steady all ones; new_game -> all outputs 0.
- Assert reset_n low during SHOW -> leds=0, busy=0 immediately, found map cleared.
